fgp_tx_sched: RTL and testbench

Packet scheduler that sequences the FGP transmit path. It walks framebuffer chunks of 512 colors (768 bytes) and chooses which chunk offset goes out next. For each packet it pulses `start` into the FGP transmitter and Ethernet TX together, holds the offset and framebuffer base address steady for the packet, and waits for end-of-frame. It then enforces an inter-packet gap before selecting the next chunk.

---
 rtl/fgp_tx_sched_pkg.sv | 28 ++
 rtl/fgp_dirty_scan.sv | 47 ++++
 rtl/fgp_tx_sched.sv | 178 +++++++++++++++++
 tb/tb_fgp_tx_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fgp_tx_sched_pkg.sv
// Shared FGP framing constants, scheduler state type and a constant width helper.
package fgp_tx_sched_pkg;

    localparam int unsigned FGP_DATA_LEN_COLORS = 512;
    localparam int unsigned FGP_OFFSET_LEN      = 1;
    localparam int unsigned FGP_PADDING_LEN     = 127;
    localparam int unsigned FGP_DATA_LEN        = 768;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_GAP
    } sched_state_t;

    // Bits needed to encode values 0..value-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width = 0;
        int unsigned span  = 1;
        while (span < value) begin
            span = span * 2;
            width++;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/fgp_dirty_scan.sv
// Per-chunk dirty bitmap with a lookup at the scan pointer; used only when
// FGP_SCHED_DIRTY_EN is defined.
module fgp_dirty_scan
    import fgp_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_CHUNKS = 150
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_all,
    input  logic       mark_req,
    input  logic [7:0] mark_idx,
    input  logic       clr_req,
    input  logic       redirty_req,
    input  logic [7:0] ptr,
    output logic       ptr_dirty,
    output logic       any_dirty
);

    logic [NUM_CHUNKS-1:0] dirty;

    // Any set source beats the START clear, so a same-cycle mark keeps the chunk dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
                if (set_all || (mark_req && mark_idx == 8'(i)) ||
                    (redirty_req && ptr == 8'(i)))
                    dirty[i] <= 1'b1;
                else if (clr_req && ptr == 8'(i))
                    dirty[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        ptr_dirty = 1'b0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (ptr == 8'(i))
                ptr_dirty = dirty[i];
        end
    end

    assign any_dirty = |dirty;

endmodule

// File: rtl/fgp_tx_sched.sv
// FGP transmit packet scheduler: walks framebuffer chunks, paces packets and gaps.
// Define FGP_SCHED_DIRTY_EN to send only chunks marked dirty instead of full sweeps.
module fgp_tx_sched
    import fgp_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_CHUNKS     = 150,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_trigger,
    input  logic        mark_req,
    input  logic [7:0]  mark_idx,
    input  logic        tx_done,
    output logic        pkt_start,
    output logic [7:0]  pkt_offset,
    output logic [16:0] pkt_base,
    output logic        busy,
    output logic        sweep_done,
    output logic        timeout_err
);

    localparam int unsigned CNT_MAX0   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX    = (CNT_MAX0 > NUM_CHUNKS) ? CNT_MAX0 : NUM_CHUNKS;
    localparam int unsigned CNT_W      = clog2(CNT_MAX + 1);
    localparam int unsigned BASE_SHIFT = clog2(FGP_DATA_LEN_COLORS);

    localparam logic [7:0]       LAST_PTR = 8'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(NUM_CHUNKS - 1);

    sched_state_t     state;
    logic [7:0]       ptr;
    logic [7:0]       ptr_next;
    logic [CNT_W-1:0] cnt;
    logic             work_pending;

    assign ptr_next = (ptr == LAST_PTR) ? '0 : ptr + 8'd1;
    assign busy     = (state != S_IDLE);
    assign pkt_base = {pkt_offset, {BASE_SHIFT{1'b0}}};

`ifdef FGP_SCHED_DIRTY_EN
    logic ptr_dirty;
    logic any_dirty;
    logic clr_req;
    logic redirty_req;
    logic mark_valid;

    assign clr_req      = (state == S_START);
    assign redirty_req  = (state == S_WAIT) && !tx_done && (cnt == TO_LAST);
    assign mark_valid   = mark_req && ({1'b0, mark_idx} < 9'(NUM_CHUNKS));
    assign work_pending = any_dirty;

    fgp_dirty_scan #(
        .NUM_CHUNKS(NUM_CHUNKS)
    ) u_dirty_scan (
        .clk        (clk),
        .rst        (rst),
        .set_all    (frame_trigger),
        .mark_req   (mark_req),
        .mark_idx   (mark_idx),
        .clr_req    (clr_req),
        .redirty_req(redirty_req),
        .ptr        (ptr),
        .ptr_dirty  (ptr_dirty),
        .any_dirty  (any_dirty)
    );
`else
    logic sweep_active;
    logic trig_latched;
    logic unused_mark;

    assign unused_mark  = ^{mark_req, mark_idx};
    assign work_pending = sweep_active | trig_latched;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            pkt_start   <= 1'b0;
            pkt_offset  <= '0;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
`ifndef FGP_SCHED_DIRTY_EN
            sweep_active <= 1'b0;
            trig_latched <= 1'b0;
`endif
        end else begin
            pkt_start   <= 1'b0;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
`ifndef FGP_SCHED_DIRTY_EN
            if (frame_trigger) begin
                if (!sweep_active) begin
                    sweep_active <= 1'b1;
                    ptr          <= '0;
                end else begin
                    trig_latched <= 1'b1;
                end
            end
`endif
            case (state)
                S_IDLE: begin
                    cnt <= '0;
`ifdef FGP_SCHED_DIRTY_EN
                    if (enable && work_pending)
                        state <= S_SELECT;
`else
                    if (enable && (work_pending || frame_trigger))
                        state <= S_SELECT;
`endif
                end
                S_SELECT: begin
`ifdef FGP_SCHED_DIRTY_EN
                    if (ptr_dirty) begin
                        state      <= S_START;
                        pkt_start  <= 1'b1;
                        pkt_offset <= ptr;
                        cnt        <= '0;
                    end else begin
                        ptr <= ptr_next;
                        if (cnt == CHK_LAST)
                            state <= S_IDLE;
                        else
                            cnt <= cnt + CNT_W'(1);
                    end
`else
                    state      <= S_START;
                    pkt_start  <= 1'b1;
                    pkt_offset <= ptr;
`endif
                end
                S_START: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        state <= S_GAP;
                        cnt   <= '0;
                        ptr   <= ptr_next;
`ifdef FGP_SCHED_DIRTY_EN
                        sweep_done <= !any_dirty && !mark_valid && !frame_trigger;
`else
                        // Finishing the last chunk consumes any latched trigger as the next sweep.
                        if (ptr == LAST_PTR) begin
                            sweep_done   <= 1'b1;
                            sweep_active <= trig_latched | frame_trigger;
                            trig_latched <= 1'b0;
                        end
`endif
                    end else if (cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_GAP;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= (enable && work_pending) ? S_SELECT : S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fgp_tx_sched.sv
// Directed self-checking bench for fgp_tx_sched (NUM_CHUNKS 4, or 8 with FGP_SCHED_DIRTY_EN).
module tb_fgp_tx_sched;

`ifdef FGP_SCHED_DIRTY_EN
    localparam int unsigned NC = 8;
`else
    localparam int unsigned NC = 4;
`endif
    localparam int unsigned GAP = 2;
    localparam int unsigned TO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_trigger;
    logic        mark_req;
    logic [7:0]  mark_idx;
    logic        tx_done;
    logic        pkt_start;
    logic [7:0]  pkt_offset;
    logic [16:0] pkt_base;
    logic        busy;
    logic        sweep_done;
    logic        timeout_err;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;

    fgp_tx_sched #(
        .NUM_CHUNKS    (NC),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .frame_trigger(frame_trigger),
        .mark_req     (mark_req),
        .mark_idx     (mark_idx),
        .tx_done      (tx_done),
        .pkt_start    (pkt_start),
        .pkt_offset   (pkt_offset),
        .pkt_base     (pkt_base),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; frame_trigger = 1'b0;
        mark_req = 1'b0; mark_idx = 8'd0; tx_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_trigger(output int unsigned tcyc);
        frame_trigger = 1'b1;
        tcyc = cyc;
        tick();
        frame_trigger = 1'b0;
    endtask

    task automatic count_starts(input int n, output int unsigned seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pkt_start === 1'b1) seen++;
        end
    endtask

    // Waits for pkt_start, optionally marks/triggers/drops enable during WAIT, then answers tx_done.
    task automatic do_packet(input int delay, input int ntrig, input bit drop_en,
                             input bit do_mark, input logic [7:0] midx,
                             output bit got, output logic [7:0] off, output logic [16:0] base,
                             output int unsigned st, output logic sd);
        got = 1'b0; off = '0; base = '0; st = 0; sd = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (pkt_start === 1'b1) got = 1'b1;
            else tick();
        end
        if (got) begin
            st = cyc; off = pkt_offset; base = pkt_base;
            if (do_mark) begin
                mark_req = 1'b1;
                mark_idx = midx;
            end
            for (int i = 0; i < delay; i++) begin
                frame_trigger = (ntrig >= 1 && i == 2) || (ntrig >= 2 && i == 5);
                if (drop_en && i == 1) enable = 1'b0;
                tick();
                mark_req = 1'b0;
            end
            frame_trigger = 1'b0;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            sd = sweep_done;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pkt_start, sweep_done, timeout_err, pkt_offset, pkt_base} !== 28'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {pkt_start, sweep_done, timeout_err, pkt_offset, pkt_base});
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else passed++;
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
        checks++;
        if ({busy, sweep_done, pkt_start} !== 3'b000)
            $display("FAIL idle_tx_done: busy/sweep_done/pkt_start %b expected 000",
                     {busy, sweep_done, pkt_start});
        else passed++;
    endtask

    task automatic test_sweep();
        int unsigned tn, st, prev;
        bit got;
        logic [7:0] off, eo;
        logic [16:0] base;
        logic sd;
        do_reset();
        enable = 1'b1;
        pulse_trigger(tn);
        checks++;
        if (busy !== 1'b1) $display("FAIL trig_select: busy %b expected 1", busy);
        else passed++;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            eo = 8'(k);
            do_packet(10, 0, 1'b0, 1'b0, 8'd0, got, off, base, st, sd);
            checks++;
            if (got !== 1'b1) $display("FAIL sweep_start%0d: no pkt_start, expected one", k);
            else passed++;
            checks++;
            if (off !== eo) $display("FAIL sweep_offset%0d: got %0d expected %0d", k, off, eo);
            else passed++;
            checks++;
            if (base !== {eo, 9'b0}) $display("FAIL sweep_base%0d: got %h expected %h", k, base, {eo, 9'b0});
            else passed++;
            checks++;
            if (sd !== (k == 3)) $display("FAIL sweep_done%0d: got %b expected %b", k, sd, (k == 3));
            else passed++;
            checks++;
            if (k == 0) begin
                if (st !== tn + 2) $display("FAIL start_latency: got cycle %0d expected %0d", st, tn + 2);
                else passed++;
            end else begin
                if (st !== prev + 14) $display("FAIL start_spacing%0d: got %0d expected %0d", k, st - prev, 14);
                else passed++;
            end
            prev = st;
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL sweep_idle: busy %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_retrigger();
        int unsigned tn, st, seen;
        bit got;
        logic [7:0] off;
        logic [16:0] base;
        logic sd;
        do_reset();
        enable = 1'b1;
        pulse_trigger(tn);
        for (int k = 0; k < 8; k++) begin
            do_packet(10, (k == 1) ? 1 : ((k == 2) ? 2 : 0), 1'b0, 1'b0, 8'd0, got, off, base, st, sd);
            checks++;
            if (got !== 1'b1 || off !== 8'(k % 4))
                $display("FAIL retrig_offset%0d: got %0d (start %b) expected %0d", k, off, got, k % 4);
            else passed++;
            checks++;
            if (sd !== (k % 4 == 3)) $display("FAIL retrig_done%0d: got %b expected %b", k, sd, (k % 4 == 3));
            else passed++;
        end
        count_starts(40, seen);
        checks++;
        if (seen !== 0) $display("FAIL retrig_extra: got %0d extra starts expected 0", seen);
        else passed++;
    endtask

    task automatic test_enable_drop();
        int unsigned tn, st, seen;
        bit got;
        logic [7:0] off;
        logic [16:0] base;
        logic sd;
        do_reset();
        enable = 1'b1;
        pulse_trigger(tn);
        do_packet(10, 0, 1'b1, 1'b0, 8'd0, got, off, base, st, sd);
        checks++;
        if (got !== 1'b1 || off !== 8'd0) $display("FAIL endrop_first: got %0d (start %b) expected 0", off, got);
        else passed++;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL endrop_idle: busy %b expected 0", busy);
        else passed++;
        count_starts(20, seen);
        checks++;
        if (seen !== 0) $display("FAIL endrop_quiet: got %0d starts expected 0", seen);
        else passed++;
        enable = 1'b1;
        do_packet(10, 0, 1'b0, 1'b0, 8'd0, got, off, base, st, sd);
        checks++;
        if (got !== 1'b1 || off !== 8'd1) $display("FAIL endrop_resume: got %0d (start %b) expected 1", off, got);
        else passed++;
    endtask

    task automatic test_timeout();
        int unsigned tn, st, tt, st2;
        bit got;
        logic [7:0] off;
        logic [16:0] base;
        logic sd;
        do_reset();
        enable = 1'b1;
        pulse_trigger(tn);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (pkt_start === 1'b1) got = 1'b1;
            else tick();
        end
        st = cyc;
        tick();
        checks++;
        if ({pkt_start, pkt_offset} !== 9'd0)
            $display("FAIL start_one_cycle: pkt_start/offset %h expected 0", {pkt_start, pkt_offset});
        else passed++;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (timeout_err === 1'b1) got = 1'b1;
        end
        tt = cyc;
        checks++;
        if (got !== 1'b1 || tt !== st + 1 + TO)
            $display("FAIL timeout_time: seen %b at cycle %0d expected cycle %0d", got, tt, st + 1 + TO);
        else passed++;
        do_packet(10, 0, 1'b0, 1'b0, 8'd0, got, off, base, st2, sd);
        checks++;
        if (got !== 1'b1 || off !== 8'd0) $display("FAIL timeout_retry: got %0d (start %b) expected 0", off, got);
        else passed++;
        checks++;
        if (st2 !== tt + 3) $display("FAIL timeout_gap: retry at %0d expected %0d", st2, tt + 3);
        else passed++;
    endtask

    task automatic test_rst_mid();
        int unsigned tn, seen;
        bit got;
        do_reset();
        enable = 1'b1;
        pulse_trigger(tn);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (pkt_start === 1'b1) got = 1'b1;
            else tick();
        end
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({busy, pkt_start, sweep_done, timeout_err, pkt_offset, pkt_base} !== 29'd0)
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {busy, pkt_start, sweep_done, timeout_err, pkt_offset, pkt_base});
        else passed++;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        checks++;
        if ({busy, sweep_done} !== 2'b00) $display("FAIL rst_late_done: busy/sweep_done %b expected 00", {busy, sweep_done});
        else passed++;
        count_starts(30, seen);
        checks++;
        if (seen !== 0) $display("FAIL rst_no_restart: got %0d starts expected 0", seen);
        else passed++;
    endtask

`ifdef FGP_SCHED_DIRTY_EN
    task automatic test_dirty_order();
        int unsigned st, seen;
        bit got;
        logic [7:0] off;
        logic [16:0] base;
        logic sd;
        do_reset();
        mark_req = 1'b1; mark_idx = 8'd5; tick();
        mark_idx = 8'd2; tick();
        mark_idx = 8'd9; tick();
        mark_req = 1'b0;
        enable = 1'b1;
        do_packet(10, 0, 1'b0, 1'b0, 8'd0, got, off, base, st, sd);
        checks++;
        if (got !== 1'b1 || off !== 8'd2 || sd !== 1'b0)
            $display("FAIL dirty_first: offset %0d done %b expected offset 2 done 0", off, sd);
        else passed++;
        do_packet(10, 0, 1'b0, 1'b0, 8'd0, got, off, base, st, sd);
        checks++;
        if (got !== 1'b1 || off !== 8'd5 || sd !== 1'b1)
            $display("FAIL dirty_second: offset %0d done %b expected offset 5 done 1", off, sd);
        else passed++;
        count_starts(40, seen);
        checks++;
        if (seen !== 0 || busy !== 1'b0) $display("FAIL dirty_quiet: starts %0d busy %b expected 0 0", seen, busy);
        else passed++;
    endtask

    task automatic test_dirty_mark_race();
        int unsigned st1, st2;
        bit got;
        logic [7:0] off;
        logic [16:0] base;
        logic sd;
        do_reset();
        enable = 1'b1;
        mark_req = 1'b1; mark_idx = 8'd3; tick(); mark_req = 1'b0;
        do_packet(10, 0, 1'b0, 1'b1, 8'd3, got, off, base, st1, sd);
        checks++;
        if (got !== 1'b1 || off !== 8'd3 || sd !== 1'b0)
            $display("FAIL race_first: offset %0d done %b expected offset 3 done 0", off, sd);
        else passed++;
        do_packet(10, 0, 1'b0, 1'b0, 8'd0, got, off, base, st2, sd);
        checks++;
        if (got !== 1'b1 || off !== 8'd3 || sd !== 1'b1)
            $display("FAIL race_resend: offset %0d done %b expected offset 3 done 1", off, sd);
        else passed++;
        checks++;
        if (st2 !== st1 + 21) $display("FAIL race_scan_time: resend at %0d expected %0d", st2, st1 + 21);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
`ifndef FGP_SCHED_DIRTY_EN
        test_sweep();
        test_retrigger();
`else
        test_dirty_order();
        test_dirty_mark_race();
`endif
        test_enable_drop();
        test_timeout();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
